// File: rtl/keeper_motion_ctrl.sv
// Keeper motion controller: takes a shot target through a valid/ready handshake,
// steps the keeper toward it once per frame, holds the save pose, then walks back
// to goal centre. Positions only change on a vblank rising edge.
module keeper_motion_ctrl #(
  parameter int unsigned X_MIN       = 212,
  parameter int unsigned X_MAX       = 612,
  parameter int unsigned X_CENTER    = 412,
  parameter int unsigned STEP        = 4,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       game_active,
  input  logic       shot_valid,
  input  logic [9:0] shot_x,
  output logic       shot_ready,
  output logic [9:0] keeper_x_pos,
  output logic       busy,
  output logic       save_done
);

  localparam logic [9:0]        XMin    = 10'(X_MIN);
  localparam logic [9:0]        XMax    = 10'(X_MAX);
  localparam logic [9:0]        XCenter = 10'(X_CENTER);
  localparam logic [9:0]        Step10  = 10'(STEP);
  localparam logic signed [10:0] Step11 = 11'(STEP);
  localparam logic [7:0]        HoldLd  = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {StIdle, StDive, StHold, StReturn} state_e;

  state_e     state_q, state_d;
  logic [9:0] pos_q, pos_d;
  logic [9:0] target_q, target_d;
  logic [7:0] hold_q, hold_d;
  logic       vblnk_q;
  logic       save_done_q, save_done_d;

  logic       frame_tick;
  logic       transfer;
  logic [9:0] step_pos;
  logic [9:0] shot_clamped;

  // Move at most STEP pixels toward tgt; lands exactly on tgt when closer than STEP.
  function automatic logic [9:0] step_toward(input logic [9:0] pos, input logic [9:0] tgt);
    logic signed [10:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    if (diff > Step11) begin
      return pos + Step10;
    end else if (diff < -Step11) begin
      return pos - Step10;
    end else begin
      return tgt;
    end
  endfunction

  // Handshake, tick detect, target clamp and step computation.
  always_comb begin
    frame_tick   = vblnk & ~vblnk_q;
    shot_ready   = (state_q == StIdle) & game_active;
    transfer     = shot_valid & shot_ready;
    shot_clamped = (shot_x < XMin) ? XMin : (shot_x > XMax) ? XMax : shot_x;
    step_pos     = step_toward(pos_q, target_q);
    keeper_x_pos = pos_q;
    busy         = (state_q != StIdle);
    save_done    = save_done_q;
  end

  // Next-state logic; a dropped game_active in DIVE/HOLD overrides any tick.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    target_d    = target_q;
    hold_d      = hold_q;
    save_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          state_d  = StDive;
          target_d = shot_clamped;
        end
      end
      StDive: begin
        if (!game_active) begin
          state_d  = StReturn;
          target_d = XCenter;
          hold_d   = '0;
        end else if (frame_tick) begin
          pos_d = step_pos;
          if (step_pos == target_q) begin
            state_d = StHold;
            hold_d  = HoldLd;
          end
        end
      end
      StHold: begin
        if (!game_active) begin
          state_d  = StReturn;
          target_d = XCenter;
          hold_d   = '0;
        end else if (frame_tick) begin
          hold_d = hold_q - 8'd1;
          if (hold_q == 8'd1) begin
            state_d  = StReturn;
            target_d = XCenter;
          end
        end
      end
      StReturn: begin
        if (frame_tick) begin
          pos_d = step_pos;
          if (step_pos == target_q) begin
            state_d     = StIdle;
            save_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pos_q       <= XCenter;
      target_q    <= XCenter;
      hold_q      <= '0;
      vblnk_q     <= 1'b0;
      save_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      target_q    <= target_d;
      hold_q      <= hold_d;
      vblnk_q     <= vblnk;
      save_done_q <= save_done_d;
    end
  end

endmodule

// File: doc/keeper_motion_ctrl.md
Name: keeper_motion_ctrl

Overview:
- Frame-synchronous controller that sequences the keeper sprite position (`keeper_x_pos`) consumed by the keeper drawing stage.
- Accepts a shot target through a valid/ready handshake, then steps the keeper toward that target once per frame.
- Holds the save pose for a fixed number of frames, then walks the keeper back to goal centre.
- Sits between game logic (shot source) and the drawing pipeline. Positions change only at frame start, so no mid-frame tearing occurs.

Parameters:
- X_MIN, 212, leftmost allowed keeper x (sprite left edge, pixels).
- X_MAX, 612, rightmost allowed keeper x (sprite left edge, pixels).
- X_CENTER, 412, rest position after reset and after every return.
- STEP, 4, maximum pixels moved per frame; legal range 1..15.
- HOLD_FRAMES, 60, frames spent in HOLD; legal range 1..255.

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-low reset
- vblnk  in  1  vertical blank from the VGA timing chain
- game_active  in  1  level; 1 while a penalty round is in progress
- shot_valid  in  1  shot target offered
- shot_x  in  10  requested keeper x
- shot_ready  out  1  controller can accept a shot
- keeper_x_pos  out  10  current keeper left-edge x, to the drawing stage
- busy  out  1  high in any state other than IDLE
- save_done  out  1  one-cycle pulse when RETURN reaches X_CENTER

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, keeper_x_pos=X_CENTER, target=X_CENTER, hold_cnt=0.
  - vblnk_q=0, busy=0, save_done=0.
  - All state lives in flops with async clear.
- Frame tick:
  - vblnk_q registers vblnk; frame_tick = vblnk & ~vblnk_q (rising edge).
  - keeper_x_pos and hold_cnt change only in a cycle where frame_tick=1.
  - A vblnk held high produces exactly one tick.
- Handshake:
  - shot_ready = (state==IDLE) & game_active, combinational.
  - Transfer occurs on a clk edge with shot_valid & shot_ready.
  - shot_x is sampled only at transfer.
  - shot_valid while not ready is ignored; no queuing.
- Target clamp: target = shot_x<X_MIN ? X_MIN : shot_x>X_MAX ? X_MAX : shot_x.
- Step arithmetic:
  - diff = target − keeper_x_pos as 11-bit signed.
  - On a tick, move by +min(STEP,diff) if diff>0, or −min(STEP,−diff) if diff<0.
  - The keeper never overshoots the target and never leaves [X_MIN, X_MAX].
- States:
  - IDLE: keeper_x_pos static. On transfer → DIVE (target loaded the same edge). busy=0.
  - DIVE: on each tick step toward target. On the tick where the new position equals target (or if position already equals target at a tick) → HOLD, load hold_cnt=HOLD_FRAMES.
  - HOLD: position static. On each tick hold_cnt−1; on the tick where hold_cnt reaches 0 → RETURN, target=X_CENTER.
  - RETURN: on each tick step toward X_CENTER. When reached → IDLE with save_done=1 for exactly one cycle, on the same edge as the transition.
- game_active=0 in DIVE or HOLD: on the next clk edge → RETURN, target=X_CENTER, hold_cnt=0. IDLE and RETURN are unaffected.
- Latency:
  - Transfer to first position change: the first frame_tick after the transfer edge.
  - keeper_x_pos updates on the edge after the tick-detect cycle, i.e. registered.
- Simultaneous events:
  - frame_tick in the same cycle as a transfer: the tick does not move the keeper; the first move is on the next tick.
  - game_active falling in the same cycle as a DIVE→HOLD tick: RETURN wins.
- Mid-operation reset: an immediate return to the reset values above; no save_done pulse.

Test Plan:
- Reset with rst=0 and vblnk toggling → keeper_x_pos=412, busy=0, save_done=0. After release, shot_ready follows game_active.
- game_active=1, shot_x=500 accepted, STEP=4:
  - keeper_x_pos 412→416→…→500 over 22 ticks, then HOLD.
  - After 60 ticks, returns 500→412 in 22 ticks.
  - save_done pulses once; busy falls on the same edge.
- shot_x=100 (below X_MIN) → clamped target 212; 50 ticks to reach 212. shot_x=900 → clamped target 612, reached in 50 ticks.
- shot_x=414 (diff=2 < STEP) → one tick moves 412→414 with no overshoot, then HOLD.
- shot_valid asserted during DIVE with shot_x=300 → shot_ready=0, ignored; trajectory to the original target unchanged.
- game_active dropped mid-DIVE at x=440 → RETURN on the next edge; 7 ticks back to 412; save_done pulses. Separately, vblnk held high for 10 cycles → exactly one step.
